// File: rtl/delay_arbiter.sv
// rtl/delay_arbiter.sv - round-robin scheduler sharing one delay counter among N_REQ requesters
// Optional macro DELAY_ARB_ABORT_EN: dropping req of the granted requester mid-count aborts the grant.
module delay_arbiter #(
    parameter int N_REQ = 4,
    parameter int CNT_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ*CNT_W-1:0]   delay_i,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         done,
    output logic                     busy,
    output logic [CNT_W-1:0]         cur_cnt
);

    localparam int IDX_W = $clog2(N_REQ);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COUNT,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   target_q, target_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;

    logic               found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W:0]     cand;
    logic [IDX_W-1:0]   idx_inc;

    // Pointer always moves one past the requester that last held the grant.
    assign idx_inc = (idx_q == IDX_W'(N_REQ - 1)) ? '0 : idx_q + IDX_W'(1);

    always_comb begin
        found   = 1'b0;
        sel_idx = '0;
        cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = {1'b0, ptr_q} + (IDX_W + 1)'(i);
            if (cand >= (IDX_W + 1)'(N_REQ)) begin
                cand = cand - (IDX_W + 1)'(N_REQ);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found   = 1'b1;
                sel_idx = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        gnt_d    = gnt_q;
        done_d   = '0;
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (found) begin
                    idx_d          = sel_idx;
                    gnt_d[sel_idx] = 1'b1;
                    target_d       = delay_i[int'(sel_idx)*CNT_W +: CNT_W];
                    cnt_d          = '0;
                    state_d        = ST_COUNT;
                end
            end
            ST_COUNT: begin
`ifdef DELAY_ARB_ABORT_EN
                if (!req[idx_q]) begin
                    state_d = ST_IDLE;
                    gnt_d   = '0;
                    ptr_d   = idx_inc;
                end else
`endif
                if (cnt_q == target_q) begin
                    state_d = ST_DONE;
                    done_d  = gnt_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                ptr_d   = idx_inc;
                gnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            idx_q    <= '0;
            cnt_q    <= '0;
            target_q <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign busy    = (state_q != ST_IDLE);
    assign cur_cnt = cnt_q;

endmodule

// File: tb/tb_delay_arbiter.sv
// tb/tb_delay_arbiter.sv - scoreboard bench for delay_arbiter with a round-robin schedule model
module tb_delay_arbiter;

    localparam int N = 4;
    localparam int W = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req;
    logic [N*W-1:0] delay_i;
    logic [N-1:0]   gnt;
    logic [N-1:0]   done;
    logic           busy;
    logic [W-1:0]   cur_cnt;

    int cyc = 0;
    int tests = 0;
    int fails = 0;
    int model_ptr = 0;
    int dly[N];
    int left[N];

    typedef struct {
        int idx;
        int cyc;
    } ev_t;

    ev_t gq[$];
    ev_t dq[$];
    logic [N-1:0] prev_gnt = '0;

    delay_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .delay_i (delay_i),
        .gnt     (gnt),
        .done    (done),
        .busy    (busy),
        .cur_cnt (cur_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        tests++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        ev_t e;
        if (rst) begin
            prev_gnt <= '0;
        end else begin
            if (gnt != '0 && prev_gnt == '0) begin
                if (gq.size() == 0) begin
                    chk("gnt_unexpected", 32'(gnt), 0);
                end else begin
                    e = gq.pop_front();
                    chk("gnt_idx", 32'(gnt), 32'(1) << e.idx);
                    chk("gnt_cycle", cyc, e.cyc);
                end
            end
            if (done != '0) begin
                chk("done_matches_gnt", 32'(done), 32'(gnt));
                if (dq.size() == 0) begin
                    chk("done_unexpected", 32'(done), 0);
                end else begin
                    e = dq.pop_front();
                    chk("done_idx", 32'(done), 32'(1) << e.idx);
                    chk("done_cycle", cyc, e.cyc);
                end
            end
            chk("busy_tracks_gnt", 32'(busy), 32'(gnt != '0));
            prev_gnt <= gnt;
        end
    end

    task automatic push_exp(input int k, input int g, input int d);
        ev_t e;
        e.idx = k;
        e.cyc = g;
        gq.push_back(e);
        e.cyc = g + d + 1;
        dq.push_back(e);
    endtask

    // Each grant occupies d+3 cycles; pick next requester with work left, searching from ptr.
    task automatic model_sched(input int s);
        int rem[N];
        int t;
        int p;
        int k;
        t = s + 1;
        p = model_ptr;
        for (int i = 0; i < N; i++) rem[i] = left[i];
        for (int g = 0; g < 2 * N + 1; g++) begin
            k = -1;
            for (int j = 0; j < N; j++) begin
                if (k < 0 && rem[(p + j) % N] > 0) k = (p + j) % N;
            end
            if (k < 0) break;
            push_exp(k, t, dly[k]);
            t = t + dly[k] + 3;
            rem[k]--;
            p = (k + 1) % N;
        end
        model_ptr = p;
    endtask

    task automatic clear_reqs();
        for (int k = 0; k < N; k++) begin
            left[k] = 0;
            dly[k]  = 0;
        end
    endtask

    task automatic begin_scn(input bit use_model);
        @(posedge clk);
        #2;
        req = '0;
        for (int k = 0; k < N; k++) begin
            delay_i[k*W +: W] = W'(dly[k]);
            if (left[k] > 0) req[k] = 1'b1;
        end
        if (use_model) model_sched(cyc);
    endtask

    task automatic run_until_idle(input int budget);
        bit fin;
        fin = 1'b0;
        for (int c = 0; c < budget && !fin; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                if (done[k]) begin
                    if (left[k] > 0) left[k]--;
                    if (left[k] == 0) req[k] = 1'b0;
                end else if (gnt[k] && left[k] == 1 && $urandom_range(0, 3) == 0) begin
                    delay_i[k*W +: W] = W'($urandom_range(0, 15));
                end
            end
            if (req == '0 && !busy) fin = 1'b1;
        end
        if (!fin) chk("idle_timeout", 0, 1);
        @(posedge clk);
        #2;
        chk("queue_drained", gq.size() + dq.size(), 0);
    endtask

    initial begin
        int g0;
        bit hit;
        bit fin;
        logic [N-1:0] mask;

        rst     = 1'b1;
        req     = '0;
        delay_i = '0;
        clear_reqs();
        repeat (2) @(negedge clk);
        chk("reset_gnt", 32'(gnt), 0);
        chk("reset_done", 32'(done), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_cur_cnt", 32'(cur_cnt), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        // Round robin with all delays 0: order 0,1,2,3,0,1,2,3.
        for (int k = 0; k < N; k++) left[k] = 2;
        begin_scn(1'b1);
        run_until_idle(100);

        clear_reqs();
        dly[0]  = 5;
        left[0] = 1;
        begin_scn(1'b1);
        run_until_idle(100);

        // Longest delay, with delay_i changed mid-count.
        clear_reqs();
        dly[2]  = 15;
        left[2] = 1;
        begin_scn(1'b1);
        g0  = cyc + 1;
        fin = 1'b0;
        for (int c = 0; c < 40 && !fin; c++) begin
            @(negedge clk);
            if (done[2]) begin
                req[2]  = 1'b0;
                left[2] = 0;
                fin     = 1'b1;
            end else if (gnt[2]) begin
                chk("cur_cnt_step", 32'(cur_cnt), cyc - g0);
                if (cyc == g0 + 4) delay_i[2*W +: W] = W'(3);
            end
        end
        if (!fin) chk("delay15_timeout", 0, 1);
        run_until_idle(20);

        // Reset in the middle of a count.
        clear_reqs();
        dly[1]  = 8;
        left[1] = 1;
        begin_scn(1'b1);
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (gnt[1] && cur_cnt == W'(3)) hit = 1'b1;
        end
        if (!hit) chk("reset_mid_timeout", 0, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_gnt", 32'(gnt), 0);
        chk("rst_mid_done", 32'(done), 0);
        chk("rst_mid_busy", 32'(busy), 0);
        chk("rst_mid_cur_cnt", 32'(cur_cnt), 0);
        gq.delete();
        dq.delete();
        req = '0;
        clear_reqs();
        repeat (2) @(negedge clk);
        chk("rst_hold_gnt", 32'(gnt), 0);
        chk("rst_hold_done", 32'(done), 0);
        rst       = 1'b0;
        model_ptr = 0;
        dly[0]  = 2;
        dly[3]  = 1;
        left[0] = 1;
        left[3] = 1;
        begin_scn(1'b1);
        run_until_idle(100);

        // Requester 1 drops its request mid-count while requester 3 waits.
        clear_reqs();
        dly[1]  = 9;
        dly[3]  = 2;
        left[1] = 1;
        left[3] = 1;
        begin_scn(1'b0);
        g0 = cyc + 1;
`ifdef DELAY_ARB_ABORT_EN
        begin
            ev_t e;
            e.idx = 1;
            e.cyc = g0;
            gq.push_back(e);
        end
        push_exp(3, g0 + 4, 2);
`else
        push_exp(1, g0, 9);
        push_exp(3, g0 + 12, 2);
`endif
        hit = 1'b0;
        for (int c = 0; c < 40 && !hit; c++) begin
            @(negedge clk);
            if (gnt[1] && cur_cnt == W'(2)) hit = 1'b1;
        end
        if (!hit) chk("abort_timeout", 0, 1);
        req[1] = 1'b0;
        run_until_idle(100);
        model_ptr = 0;

        for (int s = 0; s < 25; s++) begin
            clear_reqs();
            mask = N'($urandom_range(1, (1 << N) - 1));
            for (int k = 0; k < N; k++) begin
                if (mask[k]) begin
                    dly[k]  = $urandom_range(0, 15);
                    left[k] = $urandom_range(1, 2);
                end
            end
            begin_scn(1'b1);
            run_until_idle(200);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
